i2c_tmp10x_regfile_slave: RTL
=============================

// Module: i2c_tmp10x_regfile_slave
// PURPOSE
//  Clocked, parametrised TMP10x-style I2C temperature-sensor slave. It oversamples SCL/SDA in the Clk domain.
//  It provides a pointer-addressed register file: TEMP, CONFIG, TLOW and THIGH.
//  A fault-queued alert has comparator and interrupt modes.
//  Successor of the sensor top. Generalised in temperature width, address pins and alert mode, with full write support.
// PARAMETERS
//  ADDRESSLENGTH  7            slave address width
//  BASE_ADDRESS   7'b1001000   address; low 2 bits replaced by Addr_Pins
//  TEMP_WIDTH     12           signed temperature width (12 or 13), 0.0625 C/LSB
//  SYNC_STAGES    2            synchroniser depth on SCL and SDA_In
// PORTS
//  Clk             in   1           system clock, >= 10x SCL frequency
//  Reset           in   1           asynchronous, active-high
//  SCL             in   1           I2C clock (input only, no clock stretching)
//  SDA_In          in   1           I2C data, bus level
//  SDA_Oe          out  1           1 = pull SDA low (open-drain driver outside)
//  Addr_Pins       in   2           address strap bits
//  Temperature_In  in   TEMP_WIDTH  signed sample
//  Temp_Valid      in   1           1-Clk strobe, sample valid
//  Alert           out  1           alert pin, polarity per CONFIG.POL
//  Busy            out  1           1 between matched START and STOP
// BEHAVIOUR
//  Reset values
//   - SDA_Oe=0, Busy=0, Alert=1, FSM=IDLE, pointer=0, TEMP=0x0000.
//   - CONFIG=0x0000, TLOW=0x4B00 (75C), THIGH=0x5000 (80C), fault count=0, alert_active=0.
//  Registers: 16-bit, left-justified, selected by pointer[1:0]
//   - 0 TEMP (read-only). Value = {T, zeros}.
//   - 1 CONFIG. Bit [8]=SD, ignore Temp_Valid. Bit [9]=TM, 1=interrupt. Bit [10]=POL.
//     Bits [12:11]=F, fault queue 1/2/4/6. Other bits read 0.
//   - 2 TLOW.
//   - 3 THIGH.
//   - The low 16-TEMP_WIDTH bits of TLOW and THIGH are writable but ignored in compares.
//  Bus front end
//   - START = synced SDA falls while SCL high. STOP = SDA rises while SCL high.
//   - SDA_In is sampled on the synced SCL rise.
//   - SDA_Oe changes 1 Clk after the synced SCL fall.
//  FSM
//   - IDLE -START-> ADDR.
//   - ADDR: shift 8 bits, MSB first.
//     On match: ADDR_ACK, Busy=1. On mismatch: IGNORE, no ACK.
//   - After ADDR_ACK:
//     R/W=0: PTR -> PTR_ACK -> WR_MSB -> WR_MSB_ACK -> WR_LSB -> WR_LSB_ACK -> WR_MSB ...
//     R/W=1: RD_MSB -> RD_ACK -> RD_LSB -> RD_ACK -> RD_MSB ...
//   - PTR_ACK loads pointer[1:0]. Bits [7:2] are ignored.
//   - WR_LSB_ACK commits the 16-bit word to the pointed register.
//     A write to TEMP is ACKed and discarded. A lone MSB before STOP is discarded.
//   - RD: shadow latched at the read ADDR_ACK, so MSB and LSB are coherent. Master ACK continues.
//     Master NACK: release SDA, go to IGNORE.
//   - START in any state -> ADDR (repeated start). The pointer is kept.
//   - STOP in any state -> IDLE, SDA_Oe=0, Busy=0.
//  Temperature and alert
//   - On Temp_Valid with SD=0: TEMP <= T.
//   - Signed compare of T against TLOW[15:16-TEMP_WIDTH] and THIGH[15:16-TEMP_WIDTH].
//   - Fault counter counts consecutive qualifying samples and clears on a non-qualifying sample.
//     It saturates at F. At count==F the event fires and the counter clears.
//   - Comparator mode: T>=THIGH sets alert_active. T<TLOW clears it.
//   - Interrupt mode:
//     T>=THIGH sets alert_active and arms the low watch. Then T<TLOW sets alert_active and re-arms high.
//     Any matched read ADDR_ACK clears alert_active.
//   - Alert = alert_active ? POL : ~POL, registered.
//   - Writing CONFIG clears the fault counter.
//   - Temp_Valid in the same Clk as a register commit uses the pre-write thresholds.
//  Reset mid-transaction: SDA_Oe drops immediately (async). No partial write is committed.
// TESTING
//  - Write addr 0x48+W, ptr 0x03, 0x64, 0x00: ACK at every byte; THIGH=0x6400.
//  - Temp_Valid T=0x190 (25C), then read 0x48+R ptr0: bytes 0x19, 0x00; NACK, STOP: SDA_Oe=0, Busy=0.
//  - Addr_Pins=2'b01, address 0x48: no ACK, IGNORE until STOP. Address 0x49: ACK.
//  - CONFIG F=4, comparator mode, POL=0. 4 samples 0x500 (80C): Alert=0 after the 4th.
//    3 samples 0x300 then 1 sample 0x500: Alert stays 0.
//    4 samples 0x4A0 (74C): Alert returns to 1.
//  - TM=1, F=1: sample 0x500 -> Alert=0; read of TEMP -> Alert=1; sample 0x510 -> Alert stays 1; sample 0x400 -> Alert=0.
//  - Repeated START after the pointer byte, then read: pointer kept.
//    Reset asserted mid RD_MSB: SDA_Oe=0 in the same cycle; registers return to reset values.

Source files
------------

// File: rtl/i2c_tmp10x_regfile_slave.sv
// TMP10x-style I2C temperature-sensor slave: oversampled bus front end, pointer-addressed
// TEMP/CONFIG/TLOW/THIGH register file and a fault-queued comparator/interrupt alert.
module i2c_tmp10x_regfile_slave #(
  parameter int unsigned              ADDRESSLENGTH = 7,
  parameter logic [ADDRESSLENGTH-1:0] BASE_ADDRESS  = 7'b1001000,
  parameter int unsigned              TEMP_WIDTH    = 12,
  parameter int unsigned              SYNC_STAGES   = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         SCL,
  input  logic                         SDA_In,
  output logic                         SDA_Oe,
  input  logic [1:0]                   Addr_Pins,
  input  logic signed [TEMP_WIDTH-1:0] Temperature_In,
  input  logic                         Temp_Valid,
  output logic                         Alert,
  output logic                         Busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR_MSB,
    S_WR_MSB_ACK,
    S_WR_LSB,
    S_WR_LSB_ACK,
    S_RD_MSB,
    S_RD_ACK,
    S_RD_LSB,
    S_IGNORE
  } state_e;

  // ---------------------------------------------------------------- bus front end
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA_In};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // ---------------------------------------------------------------- state
  state_e                  state_q, state_d;
  logic [3:0]              bitcnt_q, bitcnt_d;
  logic [7:0]              rx_q, rx_d;
  logic [7:0]              tx_q, tx_d;
  logic                    oe_q, oe_d;
  logic                    busy_q, busy_d;
  logic                    rw_q, rw_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [7:0]              wr_msb_q, wr_msb_d;
  logic [15:0]             shadow_q, shadow_d;
  logic                    rd_lsb_next_q, rd_lsb_next_d;
  logic                    mack_q, mack_d;

  logic [TEMP_WIDTH-1:0]   temp_q, temp_d;
  logic [4:0]              cfg_q, cfg_d;
  logic [15:0]             tlow_q, tlow_d;
  logic [15:0]             thigh_q, thigh_d;
  logic [2:0]              fcnt_q, fcnt_d;
  logic                    alert_act_q, alert_act_d;
  logic                    arm_low_q, arm_low_d;
  logic                    alert_q;

  logic                    cfg_sd, cfg_tm, cfg_pol;
  logic [1:0]              cfg_f;
  logic [ADDRESSLENGTH-1:0] my_addr;
  logic                    addr_match;
  logic [15:0]             reg_rd;
  logic [15:0]             commit_word;
  logic                    commit;
  logic                    rd_match;

  assign cfg_sd  = cfg_q[0];
  assign cfg_tm  = cfg_q[1];
  assign cfg_pol = cfg_q[2];
  assign cfg_f   = cfg_q[4:3];

  assign my_addr     = {BASE_ADDRESS[ADDRESSLENGTH-1:2], Addr_Pins};
  assign addr_match  = (rx_q[7 -: ADDRESSLENGTH] == my_addr);
  assign commit_word = {wr_msb_q, rx_q};

  always_comb begin
    reg_rd = '0;
    case (ptr_q)
      2'd0:    reg_rd = {temp_q, {(16-TEMP_WIDTH){1'b0}}};
      2'd1:    reg_rd = {3'b000, cfg_q, 8'h00};
      2'd2:    reg_rd = tlow_q;
      default: reg_rd = thigh_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      bitcnt_q      <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      oe_q          <= 1'b0;
      busy_q        <= 1'b0;
      rw_q          <= 1'b0;
      ptr_q         <= '0;
      wr_msb_q      <= '0;
      shadow_q      <= '0;
      rd_lsb_next_q <= 1'b0;
      mack_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      oe_q          <= oe_d;
      busy_q        <= busy_d;
      rw_q          <= rw_d;
      ptr_q         <= ptr_d;
      wr_msb_q      <= wr_msb_d;
      shadow_q      <= shadow_d;
      rd_lsb_next_q <= rd_lsb_next_d;
      mack_q        <= mack_d;
    end
  end

  // Data is sampled on SCL rise; every state change and SDA drive update happens on SCL fall.
  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    oe_d          = oe_q;
    busy_d        = busy_q;
    rw_d          = rw_q;
    ptr_d         = ptr_q;
    wr_msb_d      = wr_msb_q;
    shadow_d      = shadow_q;
    rd_lsb_next_d = rd_lsb_next_q;
    mack_d        = mack_q;
    commit        = 1'b0;
    rd_match      = 1'b0;

    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      bitcnt_d = '0;
      oe_d     = 1'b0;
    end else begin
      if (scl_rise) begin
        bitcnt_d = bitcnt_q + 4'd1;
        rx_d     = {rx_q[6:0], sda_s};
        if (state_q == S_RD_ACK) mack_d = ~sda_s;
      end
      if (scl_fall) begin
        case (state_q)
          S_ADDR: begin
            if (bitcnt_q == 4'd8) begin
              bitcnt_d = '0;
              if (addr_match) begin
                state_d = S_ADDR_ACK;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
                rw_d    = rx_q[0];
                if (rx_q[0]) begin
                  shadow_d = reg_rd;
                  rd_match = 1'b1;
                end
              end else begin
                state_d = S_IGNORE;
                oe_d    = 1'b0;
              end
            end
          end
          S_ADDR_ACK: begin
            bitcnt_d = '0;
            if (rw_q) begin
              state_d = S_RD_MSB;
              tx_d    = shadow_q[15:8];
              oe_d    = ~shadow_q[15];
            end else begin
              state_d = S_PTR;
              oe_d    = 1'b0;
            end
          end
          S_PTR: begin
            if (bitcnt_q == 4'd8) begin
              state_d  = S_PTR_ACK;
              bitcnt_d = '0;
              oe_d     = 1'b1;
              ptr_d    = rx_q[1:0];
            end
          end
          S_PTR_ACK, S_WR_LSB_ACK: begin
            state_d  = S_WR_MSB;
            bitcnt_d = '0;
            oe_d     = 1'b0;
          end
          S_WR_MSB: begin
            if (bitcnt_q == 4'd8) begin
              state_d  = S_WR_MSB_ACK;
              bitcnt_d = '0;
              oe_d     = 1'b1;
              wr_msb_d = rx_q;
            end
          end
          S_WR_MSB_ACK: begin
            state_d  = S_WR_LSB;
            bitcnt_d = '0;
            oe_d     = 1'b0;
          end
          S_WR_LSB: begin
            if (bitcnt_q == 4'd8) begin
              state_d  = S_WR_LSB_ACK;
              bitcnt_d = '0;
              oe_d     = 1'b1;
              commit   = 1'b1;
            end
          end
          S_RD_MSB, S_RD_LSB: begin
            if (bitcnt_q == 4'd8) begin
              state_d       = S_RD_ACK;
              bitcnt_d      = '0;
              oe_d          = 1'b0;
              rd_lsb_next_d = (state_q == S_RD_MSB);
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
          S_RD_ACK: begin
            bitcnt_d = '0;
            if (!mack_q) begin
              state_d = S_IGNORE;
              oe_d    = 1'b0;
            end else if (rd_lsb_next_q) begin
              state_d = S_RD_LSB;
              tx_d    = shadow_q[7:0];
              oe_d    = ~shadow_q[7];
            end else begin
              state_d = S_RD_MSB;
              tx_d    = shadow_q[15:8];
              oe_d    = ~shadow_q[15];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- temperature and alert
  logic signed [TEMP_WIDTH-1:0] t_low, t_high;
  logic [2:0]                   fault_limit;
  logic [2:0]                   fcnt_inc;
  logic                         watch_low, qual, fire;

  assign t_low    = $signed(tlow_q[15 -: TEMP_WIDTH]);
  assign t_high   = $signed(thigh_q[15 -: TEMP_WIDTH]);
  assign fcnt_inc = fcnt_q + 3'd1;

  always_comb begin
    case (cfg_f)
      2'd0:    fault_limit = 3'd1;
      2'd1:    fault_limit = 3'd2;
      2'd2:    fault_limit = 3'd4;
      default: fault_limit = 3'd6;
    endcase
  end

  // Interrupt mode alternates high/low watch via arm_low; comparator mode watches by alert state.
  always_comb begin
    temp_d      = temp_q;
    cfg_d       = cfg_q;
    tlow_d      = tlow_q;
    thigh_d     = thigh_q;
    fcnt_d      = fcnt_q;
    alert_act_d = alert_act_q;
    arm_low_d   = arm_low_q;
    watch_low   = cfg_tm ? arm_low_q : alert_act_q;
    qual        = watch_low ? (Temperature_In < t_low) : (Temperature_In >= t_high);
    fire        = 1'b0;

    if (Temp_Valid && !cfg_sd) begin
      temp_d = Temperature_In;
      if (qual) begin
        if (fcnt_inc >= fault_limit) begin
          fcnt_d = '0;
          fire   = 1'b1;
        end else begin
          fcnt_d = fcnt_inc;
        end
      end else begin
        fcnt_d = '0;
      end
      if (fire) begin
        if (cfg_tm) begin
          alert_act_d = 1'b1;
          arm_low_d   = ~arm_low_q;
        end else begin
          alert_act_d = ~watch_low;
          arm_low_d   = ~watch_low;
        end
      end
    end

    if (rd_match && cfg_tm) alert_act_d = 1'b0;

    if (commit) begin
      case (ptr_q)
        2'd1: begin
          cfg_d  = commit_word[12:8];
          fcnt_d = '0;
        end
        2'd2:    tlow_d  = commit_word;
        2'd3:    thigh_d = commit_word;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      temp_q      <= '0;
      cfg_q       <= '0;
      tlow_q      <= 16'h4B00;
      thigh_q     <= 16'h5000;
      fcnt_q      <= '0;
      alert_act_q <= 1'b0;
      arm_low_q   <= 1'b0;
      alert_q     <= 1'b1;
    end else begin
      temp_q      <= temp_d;
      cfg_q       <= cfg_d;
      tlow_q      <= tlow_d;
      thigh_q     <= thigh_d;
      fcnt_q      <= fcnt_d;
      alert_act_q <= alert_act_d;
      arm_low_q   <= arm_low_d;
      alert_q     <= alert_act_q ? cfg_pol : ~cfg_pol;
    end
  end

  assign SDA_Oe = oe_q;
  assign Busy   = busy_q;
  assign Alert  = alert_q;

endmodule
